// File: rtl/multicycle_sequencer_pkg.sv
// seq_pkg: opcodes, state encoding, PC source selects and opcode class for the sequencer
package seq_pkg;
   localparam logic [3:0] OP_HALT  = 4'b0000;
   localparam logic [3:0] OP_JMP   = 4'b0001;
   localparam logic [3:0] OP_BGT   = 4'b0100;
   localparam logic [3:0] OP_BLT   = 4'b0101;
   localparam logic [3:0] OP_BEQ   = 4'b0110;
   localparam logic [3:0] OP_ANDI  = 4'b1000;
   localparam logic [3:0] OP_ORI   = 4'b1001;
   localparam logic [3:0] OP_LB    = 4'b1010;
   localparam logic [3:0] OP_SB    = 4'b1011;
   localparam logic [3:0] OP_LW    = 4'b1100;
   localparam logic [3:0] OP_SW    = 4'b1101;
   localparam logic [3:0] OP_RTYPE = 4'b1111;

   localparam logic [1:0] PC_SRC_SEQ = 2'b00;
   localparam logic [1:0] PC_SRC_BR  = 2'b01;
   localparam logic [1:0] PC_SRC_JMP = 2'b10;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC_ALU, S_EXEC_ADDR, S_EXEC_BR, S_MEM, S_WB, S_HALTED
   } state_t;

   typedef struct packed {
      logic is_alu;
      logic is_mem;
      logic is_load;
      logic is_byte;
      logic is_br;
      logic is_jmp;
      logic is_halt;
      logic is_illegal;
   } op_class_t;
endpackage

// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: unified-memory request/ready handshake between sequencer and memory
interface multicycle_sequencer_if;
   logic mem_req;
   logic mem_we;
   logic mem_byte;
   logic iord;
   logic mem_ready;
   modport master (output mem_req, mem_we, mem_byte, iord, input mem_ready);
   modport slave  (input mem_req, mem_we, mem_byte, iord, output mem_ready);
endinterface

// File: rtl/multicycle_sequencer_op_class.sv
// multicycle_sequencer_op_class: combinational opcode classification
module multicycle_sequencer_op_class
   import seq_pkg::*;
(
   input  logic [3:0] opcode,
   output op_class_t  cls
);
   // classify opcode; anything not in a known group is illegal
   always_comb begin
      cls            = '0;
      cls.is_halt    = opcode == OP_HALT;
      cls.is_jmp     = opcode == OP_JMP;
      cls.is_br      = opcode inside {OP_BGT, OP_BLT, OP_BEQ};
      cls.is_alu     = opcode inside {OP_RTYPE, OP_ANDI, OP_ORI};
      cls.is_mem     = opcode inside {OP_LB, OP_SB, OP_LW, OP_SW};
      cls.is_load    = opcode inside {OP_LB, OP_LW};
      cls.is_byte    = opcode inside {OP_LB, OP_SB};
      cls.is_illegal = !(cls.is_halt || cls.is_jmp || cls.is_br || cls.is_alu || cls.is_mem);
   end
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multicycle control FSM with retired-instruction counter
module multicycle_sequencer
   import seq_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       run,
   input  logic [3:0]                 opcode,
   input  logic                       alu_lt,
   input  logic                       alu_gt,
   input  logic                       alu_eq,
   multicycle_sequencer_if.master     mem,
   output logic                       ir_we,
   output logic                       pc_we,
   output logic [1:0]                 pc_src,
   output logic                       ab_we,
   output logic                       aluout_we,
   output logic                       reg_we,
   output logic                       wb_src,
   output logic                       halted,
   output logic                       illegal,
   output logic [CNT_W-1:0]           retired
);
   state_t             state_q, state_d;
   logic [CNT_W-1:0]   retired_q, retired_d;
   op_class_t          cls;
   logic               retire, taken;
   logic               mem_req, mem_we, mem_byte, iord;

   multicycle_sequencer_op_class u_op_class (.opcode(opcode), .cls(cls));

   assign taken = (opcode == OP_BGT && alu_gt) || (opcode == OP_BLT && alu_lt) || (opcode == OP_BEQ && alu_eq);

   // decode state (plus opcode) into control strobes and next state; reset forces everything quiet
   always_comb begin
      state_d   = state_q;
      retire    = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_byte  = 1'b0;
      iord      = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = PC_SRC_SEQ;
      ab_we     = 1'b0;
      aluout_we = 1'b0;
      reg_we    = 1'b0;
      wb_src    = 1'b0;
      halted    = 1'b0;
      illegal   = 1'b0;
      case (state_q)
         S_IDLE:      state_d = run ? S_FETCH : S_IDLE;
         S_FETCH: begin
            mem_req = 1'b1;
            ir_we   = mem.mem_ready;
            pc_we   = mem.mem_ready;
            state_d = mem.mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            ab_we   = 1'b1;
            pc_we   = cls.is_jmp;
            pc_src  = cls.is_jmp ? PC_SRC_JMP : PC_SRC_SEQ;
            illegal = cls.is_illegal;
            retire  = cls.is_jmp || cls.is_illegal;
            state_d = cls.is_halt ? S_HALTED :
                      cls.is_br   ? S_EXEC_BR :
                      cls.is_alu  ? S_EXEC_ALU :
                      cls.is_mem  ? S_EXEC_ADDR : S_FETCH;
         end
         S_EXEC_ALU: begin
            aluout_we = 1'b1;
            state_d   = S_WB;
         end
         S_EXEC_ADDR: begin
            aluout_we = 1'b1;
            state_d   = S_MEM;
         end
         S_EXEC_BR: begin
            pc_we   = taken;
            pc_src  = taken ? PC_SRC_BR : PC_SRC_SEQ;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_MEM: begin
            mem_req  = 1'b1;
            iord     = 1'b1;
            mem_we   = !cls.is_load;
            mem_byte = cls.is_byte;
            retire   = mem.mem_ready && !cls.is_load;
            state_d  = !mem.mem_ready ? S_MEM : cls.is_load ? S_WB : S_FETCH;
         end
         S_WB: begin
            reg_we  = 1'b1;
            wb_src  = cls.is_load;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_HALTED:    halted = 1'b1;
         default:     state_d = S_IDLE;
      endcase
      retired_d = retired_q + CNT_W'(retire);
      if (rst) begin
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         mem_byte  = 1'b0;
         iord      = 1'b0;
         ir_we     = 1'b0;
         pc_we     = 1'b0;
         pc_src    = PC_SRC_SEQ;
         ab_we     = 1'b0;
         aluout_we = 1'b0;
         reg_we    = 1'b0;
         wb_src    = 1'b0;
         halted    = 1'b0;
         illegal   = 1'b0;
      end
   end

   // state and retired counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   assign mem.mem_req  = mem_req;
   assign mem.mem_we   = mem_we;
   assign mem.mem_byte = mem_byte;
   assign mem.iord     = iord;
   assign retired      = retired_q;
endmodule
